// File: rtl/fpdiv_issue.sv
// fpdiv_issue: request/response front-end for the iterative fpdiv divide/sqrt core.
// One operation is in flight at a time. Each request is latched, launched on
// the core with a one-cycle start pulse, and its result (or a forced NaN on
// timeout / illegal op) is queued in a small response FIFO with backpressure.
module fpdiv_issue #(
    parameter int DEPTH   = 4,   // response FIFO entries, power of 2, >= 2
    parameter int TAGW    = 4,   // request/response tag width
    parameter int TIMEOUT = 64   // max cycles in WAIT before a timeout response
) (
    input  logic            clk,
    input  logic            reset,        // synchronous, active-low

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_rm,
    input  logic [31:0]     req_x,
    input  logic [31:0]     req_d,
    input  logic [TAGW-1:0] req_tag,

    output logic [1:0]      core_op,
    output logic            core_rm,
    output logic [31:0]     core_x,
    output logic [31:0]     core_d,
    output logic            core_start,
    input  logic            core_done,
    input  logic [31:0]     core_result,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_result,
    output logic [TAGW-1:0] rsp_tag,
    output logic [1:0]      rsp_status
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int WDW  = $clog2(TIMEOUT) + 1;

    localparam logic [31:0]   QNAN       = 32'h7FC0_0000;
    localparam logic [1:0]    ST_OK      = 2'b00;
    localparam logic [1:0]    ST_TIMEOUT = 2'b01;
    localparam logic [1:0]    ST_ILLEGAL = 2'b10;
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ERR
    } state_e;

    typedef struct packed {
        logic [31:0]     result;
        logic [TAGW-1:0] tag;
        logic [1:0]      status;
    } rsp_t;

    state_e          state_q, state_d;

    logic [1:0]      op_q;
    logic            rm_q;
    logic [31:0]     x_q;
    logic [31:0]     d_q;
    logic [TAGW-1:0] tag_q;

    logic [WDW-1:0]  wd_q;
    logic            wd_expired;

    logic [PTRW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNTW-1:0] count_q;
    rsp_t            mem_q [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    rsp_t            push_entry;
    rsp_t            head;

    assign accept     = req_valid && req_ready;
    assign pop        = rsp_ready && (count_q != '0);
    assign wd_expired = (wd_q == WD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from the same pre-edge values.
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one operation in flight, always back to IDLE after a push.
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned,
        // so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = req_op[1] ? S_ERR : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (core_done || wd_expired) state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake, launch pulse and the FIFO push entry.
    always_comb begin
        req_ready         = 1'b0;
        core_start        = 1'b0;
        push              = 1'b0;
        push_entry.result = QNAN;
        push_entry.tag    = tag_q;
        push_entry.status = ST_OK;
        case (state_q)
            S_IDLE:  req_ready = (count_q < CNTW'(DEPTH));
            S_ISSUE: core_start = 1'b1;
            S_WAIT: begin
                // A done arriving on the timeout cycle still wins.
                if (core_done) begin
                    push              = 1'b1;
                    push_entry.result = core_result;
                    push_entry.status = ST_OK;
                end else if (wd_expired) begin
                    push              = 1'b1;
                    push_entry.status = ST_TIMEOUT;
                end
            end
            S_ERR: begin
                push              = 1'b1;
                push_entry.status = ST_ILLEGAL;
            end
            default: ;
        endcase
    end

    // Request latch: operands are held on core_* until the next accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q  <= '0;
            rm_q  <= 1'b0;
            x_q   <= '0;
            d_q   <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op_q  <= req_op;
            rm_q  <= req_rm;
            x_q   <= req_x;
            d_q   <= req_d;
            tag_q <= req_tag;
        end
    end

    assign core_op = op_q;
    assign core_rm = rm_q;
    assign core_x  = x_q;
    assign core_d  = d_q;

    // Watchdog: cleared on launch, counts every cycle spent waiting for done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (state_q == S_ISSUE) begin
            wd_q <= '0;
        end else if (state_q == S_WAIT) begin
            wd_q <= wd_q + WDW'(1);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only visible
        // once count_q says they were written, so clearing them buys nothing.
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign rsp_valid  = (count_q != '0);
    assign rsp_result = head.result;
    assign rsp_tag    = head.tag;
    assign rsp_status = head.status;

endmodule

// File: tb/tb_fpdiv_issue.sv
// Directed testbench for fpdiv_issue. The bench plays the role of the core:
// it pulses core_done with a hand-chosen result after a fixed delay.
// Inputs change and outputs are observed on the falling clock edge.
module tb_fpdiv_issue;

    localparam int DEPTH   = 4;
    localparam int TAGW    = 4;
    localparam int TIMEOUT = 64;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic            req_rm;
    logic [31:0]     req_x;
    logic [31:0]     req_d;
    logic [TAGW-1:0] req_tag;
    logic [1:0]      core_op;
    logic            core_rm;
    logic [31:0]     core_x;
    logic [31:0]     core_d;
    logic            core_start;
    logic            core_done;
    logic [31:0]     core_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_result;
    logic [TAGW-1:0] rsp_tag;
    logic [1:0]      rsp_status;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    fpdiv_issue #(.DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rm      (req_rm),
        .req_x       (req_x),
        .req_d       (req_d),
        .req_tag     (req_tag),
        .core_op     (core_op),
        .core_rm     (core_rm),
        .core_x      (core_x),
        .core_d      (core_d),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_status  (rsp_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which the launch pulse is high.
    always @(posedge clk) begin
        if (core_start) start_cnt <= start_cnt + 1;
    end

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    // Present a request and hold it until accepted. Ends on the negedge
    // following the accepting posedge (DUT is then in ISSUE or ERR).
    task automatic send_req(input logic [1:0] op, input logic rm, input logic [31:0] x,
                            input logic [31:0] d, input logic [TAGW-1:0] tag);
        int n;
        req_op    = op;
        req_rm    = rm;
        req_x     = x;
        req_d     = d;
        req_tag   = tag;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_req_accept: req_ready=%b required 1 within 200 cycles", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Full legal operation: accept, wait `delay` cycles in WAIT, pulse done.
    // Ends on the negedge where the pushed response is visible.
    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] d,
                          input logic [TAGW-1:0] tag, input int delay, input logic [31:0] res);
        send_req(op, 1'b0, x, d, tag);
        repeat (delay) @(negedge clk);
        core_result = res;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid);
        end
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_core_start: got %b required 0", core_start);
        end
        checks++;
        if ({core_op, core_rm, core_x, core_d} !== 67'd0) begin
            errors++;
            $display("FAIL reset_core_operands: op=%h rm=%b x=%h d=%h required all 0",
                     core_op, core_rm, core_x, core_d);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // sqrt(4.0) = 2.0, core answers after 10 cycles.
    task automatic test_sqrt;
        int snap;
        snap = start_cnt;
        send_req(2'b01, 1'b0, 32'h4080_0000, 32'h0, 4'd3);
        checks++;
        if (core_start !== 1'b1 || core_op !== 2'b01 || core_x !== 32'h4080_0000) begin
            errors++;
            $display("FAIL sqrt_launch: start=%b op=%b x=%h required 1/01/40800000",
                     core_start, core_op, core_x);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL sqrt_wait: rsp_valid=%b core_start=%b required 0/0", rsp_valid, core_start);
        end
        @(negedge clk);
        core_result = 32'h4000_0000;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h4000_0000 || rsp_tag !== 4'd3
            || rsp_status !== 2'b00) begin
            errors++;
            $display("FAIL sqrt_rsp: valid=%b result=%h tag=%0d status=%b required 1/40000000/3/00",
                     rsp_valid, rsp_result, rsp_tag, rsp_status);
        end
        checks++;
        if (start_cnt - snap !== 1) begin
            errors++;
            $display("FAIL sqrt_start_pulses: got %0d required 1", start_cnt - snap);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL sqrt_pop_empty: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    // 3.0 / 2.0 = 1.5, operands must stay put on core_* while waiting.
    task automatic test_div;
        int bad;
        bad = 0;
        send_req(2'b00, 1'b1, 32'h4040_0000, 32'h4000_0000, 4'd5);
        for (int i = 0; i < 6; i++) begin
            if (core_op !== 2'b00 || core_rm !== 1'b1 || core_x !== 32'h4040_0000
                || core_d !== 32'h4000_0000) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL div_operands_stable: %0d unstable cycles required 0", bad);
        end
        core_result = 32'h3FC0_0000;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h3FC0_0000 || rsp_tag !== 4'd5
            || rsp_status !== 2'b00) begin
            errors++;
            $display("FAIL div_rsp: valid=%b result=%h tag=%0d status=%b required 1/3fc00000/5/00",
                     rsp_valid, rsp_result, rsp_tag, rsp_status);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Fill the FIFO, stall a fifth request, release it with one pop, drain in order.
    task automatic test_fifo_full;
        int snap;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(2'b00, 32'h3F80_0000, 32'h3F80_0000, 4'(i), 2, 32'h1000_0000 + 32'(i));
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full_ready: req_ready=%b required 0", req_ready);
        end
        snap      = start_cnt;
        req_op    = 2'b00;
        req_tag   = 4'd4;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || start_cnt !== snap) begin
            errors++;
            $display("FAIL fifo_stall: req_ready=%b new_starts=%0d required 0/0",
                     req_ready, start_cnt - snap);
        end
        checks++;
        if (rsp_tag !== 4'd0 || rsp_result !== 32'h1000_0000) begin
            errors++;
            $display("FAIL fifo_head0: tag=%0d result=%h required 0/10000000", rsp_tag, rsp_result);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_release_ready: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (core_start !== 1'b1) begin
            errors++;
            $display("FAIL fifo_fifth_launch: core_start=%b required 1", core_start);
        end
        repeat (2) @(negedge clk);
        core_result = 32'h1000_0004;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        rsp_ready   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'(i) || rsp_result !== 32'h1000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL fifo_order_%0d: valid=%b tag=%0d result=%h required 1/%0d/%h",
                         i, rsp_valid, rsp_tag, rsp_result, i, 32'h1000_0000 + 32'(i));
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    // Push and pop on the same edge: count stays at one, head moves to the new entry.
    task automatic test_back_to_back;
        run_op(2'b00, 32'h4000_0000, 32'h4000_0000, 4'd10, 1, 32'h3F80_0000);
        send_req(2'b01, 1'b0, 32'h4180_0000, 32'h0, 4'd11);
        repeat (2) @(negedge clk);
        core_result = 32'h4080_0000;
        core_done   = 1'b1;
        rsp_ready   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        rsp_ready   = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd11 || rsp_result !== 32'h4080_0000) begin
            errors++;
            $display("FAIL b2b_head: valid=%b tag=%0d result=%h required 1/11/40800000",
                     rsp_valid, rsp_tag, rsp_result);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    // Core never answers: NaN with timeout status after exactly TIMEOUT WAIT cycles.
    task automatic test_timeout;
        int early;
        early = 0;
        send_req(2'b00, 1'b0, 32'h4040_0000, 32'h0, 4'd7);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL timeout_early: %0d early response cycles required 0", early);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h7FC0_0000 || rsp_tag !== 4'd7
            || rsp_status !== 2'b01) begin
            errors++;
            $display("FAIL timeout_rsp: valid=%b result=%h tag=%0d status=%b required 1/7fc00000/7/01",
                     rsp_valid, rsp_result, rsp_tag, rsp_status);
        end
        core_result = 32'h1234_5678;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        rsp_ready   = 1'b1;
        @(negedge clk);
        rsp_ready   = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_done: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    // Done on the very cycle the watchdog expires: the real result wins.
    task automatic test_done_at_timeout;
        send_req(2'b00, 1'b0, 32'h4040_0000, 32'h4040_0000, 4'd8);
        repeat (TIMEOUT) @(negedge clk);
        core_result = 32'h3F80_0000;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h3F80_0000 || rsp_status !== 2'b00) begin
            errors++;
            $display("FAIL done_priority: valid=%b result=%h status=%b required 1/3f800000/00",
                     rsp_valid, rsp_result, rsp_status);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // op=11 is illegal: NaN with illegal status at N+2, no launch pulse.
    task automatic test_illegal;
        int snap;
        snap = start_cnt;
        send_req(2'b11, 1'b0, 32'h4000_0000, 32'h4000_0000, 4'd9);
        checks++;
        if (core_start !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err_cycle: core_start=%b rsp_valid=%b required 0/0",
                     core_start, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h7FC0_0000 || rsp_tag !== 4'd9
            || rsp_status !== 2'b10) begin
            errors++;
            $display("FAIL illegal_rsp: valid=%b result=%h tag=%0d status=%b required 1/7fc00000/9/10",
                     rsp_valid, rsp_result, rsp_tag, rsp_status);
        end
        checks++;
        if (start_cnt !== snap) begin
            errors++;
            $display("FAIL illegal_no_start: starts=%0d required 0", start_cnt - snap);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // One-cycle reset during WAIT with a response queued: everything clears,
    // and a later core_done is ignored.
    task automatic test_reset_mid;
        run_op(2'b00, 32'h4000_0000, 32'h3F80_0000, 4'd6, 1, 32'h4000_0000);
        send_req(2'b00, 1'b0, 32'h4100_0000, 32'h4000_0000, 4'd12);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || core_x !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_state: req_ready=%b rsp_valid=%b core_x=%h required 1/0/0",
                     req_ready, rsp_valid, core_x);
        end
        core_result = 32'h4080_0000;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_late_done: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_rm      = 1'b0;
        req_x       = 32'h0;
        req_d       = 32'h0;
        req_tag     = '0;
        core_done   = 1'b0;
        core_result = 32'h0;
        rsp_ready   = 1'b0;
        @(negedge clk);

        test_reset;
        test_sqrt;
        test_div;
        test_fifo_full;
        test_back_to_back;
        test_timeout;
        test_done_at_timeout;
        test_illegal;
        test_reset_mid;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
